// File: rtl/display_mux_pkg.sv
// Shared types and helpers for the display task multiplexer.
// Holds the FSM state encoding, the black pixel value and a lowest-index-wins one-hot encoder.
package display_mux_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } mux_state_e;

  localparam logic [15:0] PIX_BLACK = 16'h0000;
  localparam int MAX_TASKS = 32;

  // Isolates the lowest set bit (two's complement trick), giving index 0 highest priority.
  function automatic logic [MAX_TASKS-1:0] prio_onehot(input logic [MAX_TASKS-1:0] req);
    prio_onehot = req & (~req + MAX_TASKS'(1));
  endfunction

endpackage

// File: rtl/sw_stabiliser.sv
// Synchronises raw task switches, picks the highest-priority one and only lets it through
// as a one-cycle commit strobe once it has held steady for STABLE_CYCLES cycles.
module sw_stabiliser
  import display_mux_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] current,
  output logic [WIDTH-1:0] candidate,
  output logic             commit_ok
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand_prev;
  logic [CW-1:0]    count;

  assign candidate = WIDTH'(prio_onehot(MAX_TASKS'(sync2)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      cand_prev <= '0;
      count     <= '0;
    end else begin
      sync1     <= sw_raw;
      sync2     <= sync1;
      cand_prev <= candidate;
      if (candidate != cand_prev) begin
        count <= '0;
      end else if (count != CNT_MAX) begin
        count <= count + CW'(1);
      end
    end
  end

  // Counter saturates above CNT_COMMIT, so a steady candidate commits exactly once.
  assign commit_ok = (count == CNT_COMMIT) && (candidate == cand_prev) && (candidate != current);

endmodule

// File: rtl/display_task_mux.sv
// Task arbiter and OLED pixel mux: commits a stable switch selection, blanks the panel for a
// few frames after each change, and latches an overlay source while the overlay task is live.
module display_task_mux
  import display_mux_pkg::*;
#(
  parameter int NUM_TASKS     = 5,
  parameter int PIX_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int BLANK_FRAMES  = 2,
  parameter int OVERLAY_TASK  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_TASKS-1:0]       sel_sw,
  input  logic                       frame_begin,
  input  logic [NUM_TASKS*PIX_W-1:0] pixel_in,
  input  logic [PIX_W-1:0]           overlay_pixel,
  input  logic                       overlay_trigger,
  input  logic                       overlay_arm,
  output logic [PIX_W-1:0]           pixel_out,
  output logic [NUM_TASKS-1:0]       task_active,
  output logic                       switching,
  output logic                       overlay_active
);

  localparam int FW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);

  mux_state_e           state_q, state_d;
  logic [FW-1:0]        frame_cnt, frame_d;
  logic [NUM_TASKS-1:0] task_d;
  logic                 overlay_d;
  logic [NUM_TASKS-1:0] candidate;
  logic                 commit_ok;
  logic [PIX_W-1:0]     pix_sel;

  sw_stabiliser #(
    .WIDTH         (NUM_TASKS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sel_sw),
    .current   (task_active),
    .candidate (candidate),
    .commit_ok (commit_ok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      frame_cnt      <= '0;
      task_active    <= '0;
      overlay_active <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt      <= frame_d;
      task_active    <= task_d;
      overlay_active <= overlay_d;
    end
  end

  // A commit wins over frame counting and overlay setting, so a frame_begin on the commit
  // edge is not counted and a simultaneous overlay request is dropped.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_cnt;
    task_d    = task_active;
    overlay_d = overlay_active;
    if (commit_ok) begin
      task_d    = candidate;
      overlay_d = 1'b0;
      frame_d   = '0;
      if (BLANK_FRAMES > 0) state_d = BLANK;
    end else begin
      if (state_q == BLANK && frame_begin) begin
        frame_d = frame_cnt + FW'(1);
        if (frame_cnt == FRAME_LAST) state_d = RUN;
      end
      if (state_q == RUN && overlay_trigger && overlay_arm && task_active[OVERLAY_TASK]) begin
        overlay_d = 1'b1;
      end
    end
  end

  always_comb begin
    pix_sel = PIX_W'(PIX_BLACK);
    for (int k = 0; k < NUM_TASKS; k++) begin
      if (task_active[k]) pix_sel = pixel_in[k*PIX_W +: PIX_W];
    end
    if (state_q == BLANK) begin
      pixel_out = PIX_W'(PIX_BLACK);
    end else if (overlay_active) begin
      pixel_out = overlay_pixel;
    end else if (task_active == '0) begin
      pixel_out = PIX_W'(PIX_BLACK);
    end else begin
      pixel_out = pix_sel;
    end
  end

  assign switching = (state_q == BLANK);

endmodule

// File: doc/display_task_mux.md
# display_task_mux

Parametrised task arbiter and OLED pixel multiplexer between the per-task renderers and `Oled_Display`. It takes N switch-selected task sources and applies fixed-priority selection with input synchronisation and a stability filter. After each switch it blanks the panel for a set number of frames, and it latches an overlay (celebration) source that is armed only while a designated task is active. It replaces the ad-hoc switch/priority/celebration logic in the top level.

## Interface
Parameters:
- `NUM_TASKS`, 5: number of task sources; index 0 has the highest priority.
- `PIX_W`, 16: pixel width (RGB565).
- `STABLE_CYCLES`, 1000: consecutive `clk` cycles a candidate must hold before commit; minimum 1.
- `BLANK_FRAMES`, 2: `frame_begin` pulses of black output after each commit; 0 disables blanking.
- `OVERLAY_TASK`, 4: task index whose activity arms the overlay.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sel_sw` in NUM_TASKS: raw task switches, asynchronous.
- `frame_begin` in 1: one-cycle pulse in the `clk` domain, marking the start of an OLED frame.
- `pixel_in` in NUM_TASKS*PIX_W: task pixels; task k occupies bits [k*PIX_W +: PIX_W].
- `overlay_pixel` in PIX_W: overlay renderer pixel.
- `overlay_trigger` in 1: overlay request (level, e.g. btnC).
- `overlay_arm` in 1: extra arming condition (e.g. correct digits shown).
- `pixel_out` out PIX_W: pixel data to the OLED driver.
- `task_active` out NUM_TASKS: committed one-hot selection, or all-zero; drives the LEDs and task enables.
- `switching` out 1: high while blanking.
- `overlay_active` out 1: overlay latched.

## Operation
- **Synchronisation:** `sel_sw` passes through a 2-flop synchroniser.
- **Candidate:** the lowest set index of the synchronised switches, one-hot. If no switch is set, the candidate is none (all-zero).
- **Stability counter:**
  - Clears when the candidate differs from its value on the previous cycle.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - Commit fires when the counter equals STABLE_CYCLES-1, the candidate is unchanged, and the candidate differs from `task_active`.
- **FSM states:**
  - RUN: output follows the committed task.
  - BLANK: output is black after a commit.
- **Transitions:**
  - RUN to BLANK on a commit, if BLANK_FRAMES>0. `task_active` loads the candidate on the same edge and the frame counter clears.
  - With BLANK_FRAMES=0, a commit updates `task_active` and the FSM stays in RUN.
  - In BLANK, each `frame_begin` increments the frame counter. On the pulse that makes it BLANK_FRAMES, the FSM returns to RUN at the next edge.
  - A commit while in BLANK updates `task_active`, clears the frame counter and stays in BLANK.
- **Overlay:**
  - Set when `overlay_trigger & overlay_arm`, the FSM is in RUN, and `task_active[OVERLAY_TASK]` is 1.
  - Cleared on any commit.
  - Clearing has priority over setting in the same cycle.
- **`pixel_out` priority (combinational):**
  1. BLANK gives 0.
  2. `overlay_active` gives `overlay_pixel`.
  3. `task_active` all-zero gives 0.
  4. Otherwise the selected `pixel_in` slice.
- **`switching`** is 1 exactly while in BLANK.

## Timing
- **Reset values:**
  - `task_active`=0, FSM=RUN, `overlay_active`=0, `switching`=0.
  - Counters and synchroniser are 0.
  - `pixel_out`=0, because no task is active.
- **Switch-to-commit latency:** a `sel_sw` change that is stable from edge 0 updates `task_active` at edge STABLE_CYCLES+2 (2 synchroniser edges plus STABLE_CYCLES counting edges).
- **Glitch rejection:** a glitch shorter than STABLE_CYCLES cycles at the synchroniser output never commits.
- **Pixel path:** `pixel_in` to `pixel_out` has zero latency; all selects are registered.
- **Overlay latency:** `overlay_active` asserts 1 edge after the set condition holds.
- **Frame count:** a `frame_begin` on the commit edge itself is not counted.
- **Mid-operation reset:** reset asserted mid-blank or mid-count returns the block to the reset values immediately, without waiting for a clock edge.

## Structure
- **Package `display_mux_pkg`:** state enum {RUN, BLANK}, `PIX_BLACK`=16'h0000, and a priority one-hot function.
- **Sub-module `sw_stabiliser`:**
  - Contains the synchroniser, the priority encode and the stability counter.
  - Parametrised by WIDTH and STABLE_CYCLES.
  - Outputs the candidate and a one-cycle `commit_ok` strobe.
- **Top of this block:** the FSM, frame counter, overlay latch and the pixel mux.

## Test plan
All scenarios use NUM_TASKS=5, STABLE_CYCLES=4, BLANK_FRAMES=2, OVERLAY_TASK=4, and task k driving `pixel_in` = 16'h1000*(k+1).
- **Reset and basic commit:** release reset with `sel_sw`=0, then set `sel_sw`=5'b00110 at edge 0.
  - `pixel_out`=0 before the commit.
  - `task_active`=5'b00010 at edge 6; `switching`=1 from the same edge.
  - `pixel_out`=0 during blanking.
  - After the 2nd `frame_begin`, `pixel_out`=16'h2000.
- **Glitch rejection:** pulse `sel_sw`[0] for 3 cycles while task 1 is committed. Neither `task_active` nor `switching` changes.
- **Re-commit during blank:** change the switches mid-BLANK to `sel_sw`=5'b01000.
  - `task_active`=5'b01000 once stable.
  - The frame counter restarts; two further `frame_begin` pulses are needed to leave BLANK.
- **Overlay:** with task 4 committed and in RUN, assert trigger and arm for 1 cycle.
  - `overlay_active`=1 and `pixel_out`=`overlay_pixel`.
  - A later commit to task 0 clears the overlay on the commit edge.
- **Overlay arming gate:** assert the trigger with task 3 active, or with `overlay_arm`=0. `overlay_active` stays 0.
- **Asynchronous reset mid-blank:** assert `reset_n`=0 during BLANK between clock edges. All outputs return to their reset values without waiting for a clock edge.
